rtc_top: RTL and testbench

RTC_TOP -- requirements
Module: rtc_top

---
 rtl/rtc_pkg.sv | 95 +++++++++
 rtl/rtc_bus_cycle.sv | 99 +++++++++
 rtl/rtc_top.sv | 100 ++++++++++
 tb/tb_rtc_top.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// Shared constants and types for the RTC bus sequencer: register map, command
// codes, frame phase boundaries, timer defaults and the frame lookup table.
package rtc_pkg;

  typedef logic [4:0] cnt_t;

  localparam cnt_t C_ADDR_CS_LO = 5'd2;
  localparam cnt_t C_ADDR_CS_HI = 5'd9;
  localparam cnt_t C_DATA_LO    = 5'd12;
  localparam cnt_t C_DATA_CS_LO = 5'd14;
  localparam cnt_t C_DATA_CS_HI = 5'd21;
  localparam cnt_t C_DATA_HI    = 5'd23;
  localparam cnt_t C_LAST       = 5'd31;
  localparam cnt_t C_CAPTURE    = C_DATA_CS_HI;

  localparam logic [7:0] ADDR_CTRL    = 8'h02;
  localparam logic [7:0] ADDR_INIT2   = 8'h10;
  localparam logic [7:0] ADDR_SEC     = 8'h21;
  localparam logic [7:0] ADDR_CRONO_S = 8'h41;
  localparam logic [7:0] ADDR_CRONO_M = 8'h42;
  localparam logic [7:0] ADDR_CRONO_H = 8'h43;

  localparam logic [7:0] INIT_DATA0 = 8'h10;
  localparam logic [7:0] INIT_DATA1 = 8'h00;
  localparam logic [7:0] INIT_DATA2 = 8'hD2;

  localparam logic [7:0] CMD_READ  = 8'hF0;
  localparam logic [7:0] CMD_WRITE = 8'hF1;
  localparam logic [7:0] CMD_CRONO = 8'hF2;

  localparam logic [7:0] CRONO_S = 8'h00;
  localparam logic [7:0] CRONO_M = 8'h01;
  localparam logic [7:0] CRONO_H = 8'h00;

  typedef enum logic [2:0] {
    ST_RST, ST_INIT, ST_IDLE_SEL, ST_READ, ST_WRITE, ST_CRONO
  } state_t;

  // rw: 1 = read frame, 0 = write frame; cmd_only frames stop after the address phase.
  typedef struct packed {
    logic       rw;
    logic       cmd_only;
    logic [7:0] addr;
    logic [7:0] data;
  } frame_t;

  function automatic logic [2:0] last_idx(input state_t s);
    case (s)
      ST_INIT:  return 3'd2;
      ST_READ:  return 3'd6;
      ST_WRITE: return 3'd6;
      ST_CRONO: return 3'd3;
      default:  return 3'd0;
    endcase
  endfunction

  function automatic frame_t frame_desc(input state_t s, input logic [2:0] idx);
    frame_t f;
    f = '0;
    case (s)
      ST_INIT: begin
        f.addr = (idx == 3'd2) ? ADDR_INIT2 : ADDR_CTRL;
        f.data = (idx == 3'd0) ? INIT_DATA0 : ((idx == 3'd1) ? INIT_DATA1 : INIT_DATA2);
      end
      ST_READ: begin
        if (idx == 3'd0) begin
          f.cmd_only = 1'b1;
          f.addr     = CMD_READ;
        end else begin
          f.rw   = 1'b1;
          f.addr = ADDR_SEC + {5'd0, idx} - 8'd1;
        end
      end
      ST_WRITE: begin
        if (idx == 3'd6) begin
          f.cmd_only = 1'b1;
          f.addr     = CMD_WRITE;
        end else begin
          f.addr = ADDR_SEC + {5'd0, idx};
        end
      end
      ST_CRONO: begin
        case (idx)
          3'd0:    begin f.addr = ADDR_CRONO_S; f.data = CRONO_S; end
          3'd1:    begin f.addr = ADDR_CRONO_M; f.data = CRONO_M; end
          3'd2:    begin f.addr = ADDR_CRONO_H; f.data = CRONO_H; end
          default: begin f.cmd_only = 1'b1; f.addr = CMD_CRONO; end
        endcase
      end
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rtc_bus_cycle.sv
// One 32-clock multiplexed address/data bus frame. Frame parameters are latched
// on i_start; with no frame active the bus idles with strobes high and AD = 0x00.
module rtc_bus_cycle
  import rtc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_rw,
  input  logic       i_cmd_only,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_data,
  input  logic [7:0] i_ad_in,
  output logic       o_done,
  output logic       o_rd_valid,
  output logic [7:0] o_rdata,
  output logic [7:0] o_ad_out,
  output logic       o_ad_oe,
  output logic       o_cs_n,
  output logic       o_rd_n,
  output logic       o_wr_n,
  output logic       o_aod
);

  logic       r_active;
  cnt_t       r_c;
  logic       r_rw;
  logic       r_cmd_only;
  logic [7:0] r_addr;
  logic [7:0] r_data;
  logic       w_addr_ph, w_data_ph, w_strb_a, w_strb_d;

  // NOTE: async reset clears r_active, which alone forces every bus output idle;
  // sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active   <= 1'b0;
      r_c        <= '0;
      r_rw       <= 1'b0;
      r_cmd_only <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else if (i_start) begin
      r_active   <= 1'b1;
      r_c        <= '0;
      r_rw       <= i_rw;
      r_cmd_only <= i_cmd_only;
      r_addr     <= i_addr;
      r_data     <= i_data;
    end else if (r_active) begin
      if (r_c == C_LAST) r_active <= 1'b0;
      r_c <= r_c + 5'd1;
    end
  end

  assign w_addr_ph = (r_c < C_DATA_LO);
  assign w_data_ph = (r_c >= C_DATA_LO) && (r_c <= C_DATA_HI);
  assign w_strb_a  = (r_c >= C_ADDR_CS_LO) && (r_c <= C_ADDR_CS_HI);
  assign w_strb_d  = (r_c >= C_DATA_CS_LO) && (r_c <= C_DATA_CS_HI);

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    o_cs_n   = 1'b1;
    o_rd_n   = 1'b1;
    o_wr_n   = 1'b1;
    o_aod    = 1'b1;
    o_ad_out = 8'h00;
    o_ad_oe  = 1'b1;
    if (r_active) begin
      if (w_addr_ph) begin
        o_aod    = 1'b0;
        o_ad_out = r_addr;
        if (w_strb_a) begin
          o_cs_n = 1'b0;
          o_wr_n = 1'b0;
        end
      end else if (w_data_ph && !r_cmd_only) begin
        if (r_rw) begin
          o_ad_oe = 1'b0;
          if (w_strb_d) begin
            o_cs_n = 1'b0;
            o_rd_n = 1'b0;
          end
        end else begin
          o_ad_out = r_data;
          if (w_strb_d) begin
            o_cs_n = 1'b0;
            o_wr_n = 1'b0;
          end
        end
      end
    end
  end

  assign o_done     = r_active && (r_c == C_LAST);
  assign o_rd_valid = r_active && r_rw && !r_cmd_only && (r_c == C_CAPTURE);
  assign o_rdata    = i_ad_in;

endmodule

// File: rtl/rtc_top.sv
// RTC bus sequencer: runs INIT after reset, then back-to-back READ / WRITE /
// CRONO sequences chosen at each sequence end, capturing read bytes into datos_rtc.
module rtc_top
  import rtc_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic        Escribir,
  input  logic        ProgramarCrono,
  output logic        ChipSelect,
  output logic        Read,
  output logic        Write,
  output logic        AoD,
  output logic        bit_inicio1,
  inout  wire  [7:0]  AD,
  output logic [47:0] datos_rtc
);

  state_t      r_state, w_nstate;
  logic [2:0]  r_idx, w_nidx, w_byte;
  logic        r_pc_d, r_pend;
  logic        w_pc_rise, w_start, w_done, w_rd_valid, w_ad_oe, w_crono_start;
  logic [7:0]  w_rdata, w_ad_out;
  frame_t      w_frame;
  logic [47:0] r_datos;

  assign w_pc_rise = ProgramarCrono & ~r_pc_d;

  // A new frame always starts at the boundary; IDLE_SEL is resolved in the same cycle.
  always_comb begin
    w_start  = 1'b0;
    w_nstate = r_state;
    w_nidx   = r_idx;
    case (r_state)
      ST_RST: begin
        w_start  = 1'b1;
        w_nstate = ST_INIT;
        w_nidx   = 3'd0;
      end
      default: begin
        if (w_done) begin
          w_start = 1'b1;
          if (r_idx == last_idx(r_state)) begin
            w_nstate = ST_IDLE_SEL;
            w_nidx   = 3'd0;
          end else begin
            w_nidx = r_idx + 3'd1;
          end
        end
      end
    endcase
    if (w_nstate == ST_IDLE_SEL)
      w_nstate = (r_pend | w_pc_rise) ? ST_CRONO : (Escribir ? ST_WRITE : ST_READ);
    w_frame       = frame_desc(w_nstate, w_nidx);
    w_crono_start = w_start && (w_nstate == ST_CRONO) && (w_nidx == 3'd0);
  end

  assign w_byte = r_idx - 3'd1;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_RST;
      r_idx   <= '0;
      r_pc_d  <= 1'b0;
      r_pend  <= 1'b0;
      r_datos <= '0;
    end else begin
      r_state <= w_nstate;
      r_idx   <= w_nidx;
      r_pc_d  <= ProgramarCrono;
      r_pend  <= (r_pend | w_pc_rise) & ~w_crono_start;
      if (w_rd_valid) r_datos[{w_byte, 3'b000} +: 8] <= w_rdata;
    end
  end

  rtc_bus_cycle u_bus (
    .clk        (clk),
    .rst_n      (Reset),
    .i_start    (w_start),
    .i_rw       (w_frame.rw),
    .i_cmd_only (w_frame.cmd_only),
    .i_addr     (w_frame.addr),
    .i_data     (w_frame.data),
    .i_ad_in    (AD),
    .o_done     (w_done),
    .o_rd_valid (w_rd_valid),
    .o_rdata    (w_rdata),
    .o_ad_out   (w_ad_out),
    .o_ad_oe    (w_ad_oe),
    .o_cs_n     (ChipSelect),
    .o_rd_n     (Read),
    .o_wr_n     (Write),
    .o_aod      (AoD)
  );

  assign AD          = w_ad_oe ? w_ad_out : 8'hzz;
  assign bit_inicio1 = (r_state == ST_INIT);
  assign datos_rtc   = r_datos;

endmodule

// File: tb/tb_rtc_top.sv
// Self-checking bench for rtc_top: a frame-list reference model predicts every
// bus cycle, init flag and captured time byte under directed and random stimulus.
module tb_rtc_top;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Escribir = 1'b0;
  logic        ProgramarCrono = 1'b0;
  logic        ChipSelect, Read, Write, AoD, bit_inicio1;
  logic [47:0] datos_rtc;
  wire  [7:0]  ad;
  logic        tb_ad_en = 1'b0;
  logic [7:0]  tb_ad_val = 8'h00;

  assign ad = tb_ad_en ? tb_ad_val : 8'hzz;

  always #5 clk = ~clk;

  rtc_top dut (
    .clk            (clk),
    .Reset          (Reset),
    .Escribir       (Escribir),
    .ProgramarCrono (ProgramarCrono),
    .ChipSelect     (ChipSelect),
    .Read           (Read),
    .Write          (Write),
    .AoD            (AoD),
    .bit_inicio1    (bit_inicio1),
    .AD             (ad),
    .datos_rtc      (datos_rtc)
  );

  typedef enum {SQ_INIT, SQ_READ, SQ_WRITE, SQ_CRONO} seq_e;
  localparam int K_WR = 0, K_RD = 1, K_CMD = 2;
  typedef struct {
    int         kind;
    logic [7:0] addr;
    logic [7:0] data;
    seq_e       seq;
  } frame_s;

  frame_s      fq[$];
  frame_s      cur;
  bit          m_rst = 1'b1;
  int          m_c = 0;
  bit          m_pend = 1'b0;
  bit          m_pc_prev = 1'b0;
  logic [47:0] m_datos = '0;
  logic [7:0]  rd_val[6];
  bit          first_read = 1'b1;
  int          n_tests = 0;
  int          n_fail = 0;

  function automatic frame_s mk(int k, logic [7:0] a, logic [7:0] d, seq_e s);
    frame_s f;
    f.kind = k; f.addr = a; f.data = d; f.seq = s;
    return f;
  endfunction

  function automatic void push_seq(seq_e s);
    case (s)
      SQ_INIT: begin
        fq.push_back(mk(K_WR, 8'h02, 8'h10, s));
        fq.push_back(mk(K_WR, 8'h02, 8'h00, s));
        fq.push_back(mk(K_WR, 8'h10, 8'hD2, s));
      end
      SQ_READ: begin
        fq.push_back(mk(K_CMD, 8'hF0, 8'h00, s));
        for (int i = 0; i < 6; i++) begin
          fq.push_back(mk(K_RD, 8'(8'h21 + i), 8'h00, s));
          rd_val[i] = 8'($urandom);
        end
        if (first_read) rd_val[0] = 8'h45;
        first_read = 1'b0;
      end
      SQ_WRITE: begin
        for (int i = 0; i < 6; i++) fq.push_back(mk(K_WR, 8'(8'h21 + i), 8'h00, s));
        fq.push_back(mk(K_CMD, 8'hF1, 8'h00, s));
      end
      default: begin
        fq.push_back(mk(K_WR, 8'h41, 8'h00, s));
        fq.push_back(mk(K_WR, 8'h42, 8'h01, s));
        fq.push_back(mk(K_WR, 8'h43, 8'h00, s));
        fq.push_back(mk(K_CMD, 8'hF2, 8'h00, s));
      end
    endcase
  endfunction

  // Model state after a rising edge, using the inputs the DUT saw at that edge.
  task automatic model_advance();
    bit rise;
    if (!Reset) begin
      m_rst = 1'b1; fq.delete(); m_pend = 1'b0; m_pc_prev = 1'b0; m_datos = '0; m_c = 0;
    end else begin
      rise = ProgramarCrono && !m_pc_prev;
      m_pc_prev = ProgramarCrono;
      if (rise) m_pend = 1'b1;
      if (m_rst) begin
        m_rst = 1'b0;
        push_seq(SQ_INIT);
        cur = fq.pop_front();
        m_c = 0;
      end else begin
        if (cur.kind == K_RD && m_c == 21)
          m_datos[8*(cur.addr - 8'h21) +: 8] = rd_val[cur.addr - 8'h21];
        if (m_c == 31) begin
          m_c = 0;
          if (fq.size() == 0) begin
            if (m_pend) begin m_pend = 1'b0; push_seq(SQ_CRONO); end
            else if (Escribir) push_seq(SQ_WRITE);
            else push_seq(SQ_READ);
          end
          cur = fq.pop_front();
        end else begin
          m_c++;
        end
      end
    end
    tb_ad_en  = !m_rst && cur.kind == K_RD && m_c >= 12 && m_c <= 23;
    tb_ad_val = tb_ad_en ? rd_val[cur.addr - 8'h21] : 8'h00;
  endtask

  task automatic check_cycle();
    logic [3:0] obs_s, exp_s;
    logic [7:0] exp_ad;
    bit         ad_def, in_2_9, in_14_21;
    in_2_9   = m_c >= 2 && m_c <= 9;
    in_14_21 = m_c >= 14 && m_c <= 21;
    ad_def   = 1'b1;
    exp_ad   = 8'h00;
    if (m_rst) begin
      exp_s = 4'b1111;
    end else begin
      exp_s[3] = !(in_2_9 || (cur.kind != K_CMD && in_14_21));
      exp_s[2] = !(cur.kind == K_RD && in_14_21);
      exp_s[1] = !(in_2_9 || (cur.kind == K_WR && in_14_21));
      exp_s[0] = m_c >= 12;
      if (m_c < 12) exp_ad = cur.addr;
      else if (m_c <= 23) begin
        if (cur.kind == K_WR) exp_ad = cur.data;
        else if (cur.kind == K_RD) exp_ad = rd_val[cur.addr - 8'h21];
        else ad_def = 1'b0;
      end
    end
    obs_s = {ChipSelect, Read, Write, AoD};
    n_tests++;
    assert (obs_s === exp_s) else begin
      n_fail++;
      $error("FAIL strobes c=%0d cs/rd/wr/aod obs=%b exp=%b", m_c, obs_s, exp_s);
    end
    if (ad_def) begin
      n_tests++;
      assert (ad === exp_ad) else begin
        n_fail++;
        $error("FAIL ad_bus c=%0d obs=%h exp=%h", m_c, ad, exp_ad);
      end
    end
    n_tests++;
    assert (bit_inicio1 === (!m_rst && cur.seq == SQ_INIT)) else begin
      n_fail++;
      $error("FAIL bit_inicio1 c=%0d obs=%b exp=%b", m_c, bit_inicio1, !m_rst && cur.seq == SQ_INIT);
    end
    n_tests++;
    assert (datos_rtc === m_datos) else begin
      n_fail++;
      $error("FAIL datos_rtc c=%0d obs=%h exp=%h", m_c, datos_rtc, m_datos);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_advance();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    bit found;
    #2 Reset = 1'b0;
    run(4);

    // Power-up INIT followed by the first READ (sec byte returns 0x45).
    Reset = 1'b1;
    run(96 + 7 * 32);
    n_tests++;
    assert (datos_rtc[7:0] === 8'h45) else begin
      n_fail++;
      $error("FAIL first_sec obs=%h exp=45", datos_rtc[7:0]);
    end
    run(2 * 7 * 32);

    // One-clock ProgramarCrono pulse in the middle of a READ sequence.
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      step();
      found = !m_rst && cur.seq == SQ_READ && fq.size() == 3 && m_c == 10;
    end
    n_tests++;
    assert (found) else begin n_fail++; $error("FAIL wait_mid_read obs=0 exp=1"); end
    ProgramarCrono = 1'b1;
    step();
    ProgramarCrono = 1'b0;
    run(3 * 32 + 4 * 32 + 7 * 32);

    // Escribir held high for 400 us.
    Escribir = 1'b1;
    run(40000);
    Escribir = 1'b0;
    run(2 * 7 * 32);

    // Random mix of Escribir changes and ProgramarCrono pulses.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) Escribir = ~Escribir;
      ProgramarCrono = ($urandom_range(0, 299) == 0);
      step();
    end
    ProgramarCrono = 1'b0;

    // Reset asserted at c=16 of a WRITE data frame.
    Escribir = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      found = !m_rst && cur.seq == SQ_WRITE && cur.kind == K_WR && m_c == 16;
    end
    n_tests++;
    assert (found) else begin n_fail++; $error("FAIL wait_write_c16 obs=0 exp=1"); end
    Reset = 1'b0;
    #1;
    n_tests++;
    assert ({ChipSelect, Read, Write, AoD, bit_inicio1, ad, datos_rtc} === {4'b1111, 1'b0, 8'h00, 48'h0})
    else begin
      n_fail++;
      $error("FAIL async_reset cs/rd/wr/aod=%b%b%b%b init=%b ad=%h datos=%h exp 1111/0/00/0",
             ChipSelect, Read, Write, AoD, bit_inicio1, ad, datos_rtc);
    end
    Escribir = 1'b0;
    run(3);
    Reset = 1'b1;
    run(96 + 7 * 32 + 32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
